// File: rtl/normalize_shift_reg_pkg.sv
// rtl/normalize_shift_reg_pkg.sv - shared FSM state type and count-width helper
package norm_shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // The count tops out at n-1, so $clog2(n) bits always suffice.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/normalize_shift_reg_if.sv
// rtl/normalize_shift_reg_if.sv - request/result bundle for the normaliser
interface normalize_shift_reg_if
  import norm_shift_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 8
);
  localparam int CNT_W = cnt_width(DATA_W);

  logic              start;
  logic [DATA_W-1:0] data_in;
  logic              busy;
  logic              done;
  logic [OUT_W-1:0]  shifted_out;
  logic [CNT_W-1:0]  shift_count;
  logic              zero;

  modport master (
    output start, data_in,
    input  busy, done, shifted_out, shift_count, zero
  );

  modport slave (
    input  start, data_in,
    output busy, done, shifted_out, shift_count, zero
  );
endinterface

// File: rtl/normalize_shift_reg.sv
// rtl/normalize_shift_reg.sv - iterative left-normaliser: shifts until the MSB is set,
// reporting the top slice and the number of shifts applied.
module normalize_shift_reg
  import norm_shift_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  normalize_shift_reg_if.slave  bus
);
  localparam int CNT_W = cnt_width(DATA_W);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OUT_W-1:0]  shifted_out_q, shifted_out_d;
  logic [CNT_W-1:0]  shift_count_q, shift_count_d;
  logic              zero_q, zero_d;

  always_comb begin
    state_d       = state_q;
    data_d        = data_q;
    cnt_d         = cnt_q;
    shifted_out_d = shifted_out_q;
    shift_count_d = shift_count_q;
    zero_d        = zero_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          data_d = bus.data_in;
          cnt_d  = '0;
          if (bus.data_in == '0) begin
            state_d       = DONE;
            zero_d        = 1'b1;
            shifted_out_d = '0;
            shift_count_d = '0;
          end else begin
            state_d = SHIFT;
            zero_d  = 1'b0;
          end
        end
      end
      SHIFT: begin
        // Results are published only on capture so they stay stable while shifting.
        if (data_q[DATA_W-1]) begin
          shifted_out_d = data_q[DATA_W-1 -: OUT_W];
          shift_count_d = cnt_q;
          state_d       = DONE;
        end else begin
          data_d = {data_q[DATA_W-2:0], 1'b0};
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      data_q        <= '0;
      cnt_q         <= '0;
      shifted_out_q <= '0;
      shift_count_q <= '0;
      zero_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      data_q        <= data_d;
      cnt_q         <= cnt_d;
      shifted_out_q <= shifted_out_d;
      shift_count_q <= shift_count_d;
      zero_q        <= zero_d;
    end
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == DONE);
  assign bus.shifted_out = shifted_out_q;
  assign bus.shift_count = shift_count_q;
  assign bus.zero        = zero_q;

endmodule

// File: tb/tb_normalize_shift_reg.sv
// tb/tb_normalize_shift_reg.sv - directed self-checking bench for normalize_shift_reg
module tb_normalize_shift_reg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  normalize_shift_reg_if #(.DATA_W(16), .OUT_W(8)) a_if ();
  normalize_shift_reg_if #(.DATA_W(32), .OUT_W(4)) b_if ();

  normalize_shift_reg #(.DATA_W(16), .OUT_W(8)) dut_a (
    .clk(clk), .rst(rst), .bus(a_if.slave)
  );
  normalize_shift_reg #(.DATA_W(32), .OUT_W(4)) dut_b (
    .clk(clk), .rst(rst), .bus(b_if.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Latency counts edges, with the accepting edge as 1; 0 means the budget expired.
  task automatic wait_a(input int pulse_at, output int lat);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (i == 1) a_if.start = 1'b0;
      if (a_if.done) begin
        lat = i;
        break;
      end
      if (i == pulse_at) begin
        a_if.start   = 1'b1;
        a_if.data_in = 16'h8000;
      end
      if (i == pulse_at + 1) a_if.start = 1'b0;
    end
  endtask

  task automatic wait_b(output int lat);
    lat = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (i == 1) b_if.start = 1'b0;
      if (b_if.done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int lat;
    a_if.start = 1'b1; a_if.data_in = 16'h8000;
    b_if.start = 1'b0; b_if.data_in = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (a_if.busy !== 1'b0 || a_if.done !== 1'b0) begin n_bad++; $display("FAIL reset_a_flags busy=%0b done=%0b want 0 0", a_if.busy, a_if.done); end
    n_cmp++; if (a_if.shifted_out !== 8'h00 || a_if.shift_count !== 4'd0 || a_if.zero !== 1'b0) begin n_bad++; $display("FAIL reset_a_outs so=%h sc=%0d z=%0b want 00 0 0", a_if.shifted_out, a_if.shift_count, a_if.zero); end
    n_cmp++; if (b_if.busy !== 1'b0 || b_if.shifted_out !== 4'h0 || b_if.shift_count !== 5'd0) begin n_bad++; $display("FAIL reset_b busy=%0b so=%h sc=%0d want 0 0 0", b_if.busy, b_if.shifted_out, b_if.shift_count); end
    rst = 1'b0;
    wait_a(0, lat);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL msb_latency got=%0d want=2", lat); end
    n_cmp++; if (a_if.shifted_out !== 8'h80 || a_if.shift_count !== 4'd0 || a_if.zero !== 1'b0) begin n_bad++; $display("FAIL msb_result so=%h sc=%0d z=%0b want 80 0 0", a_if.shifted_out, a_if.shift_count, a_if.zero); end
    n_cmp++; if (a_if.busy !== 1'b1) begin n_bad++; $display("FAIL busy_in_done got=%0b want=1", a_if.busy); end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (a_if.done !== 1'b0 || a_if.busy !== 1'b0) begin n_bad++; $display("FAIL done_pulse done=%0b busy=%0b want 0 0", a_if.done, a_if.busy); end
    n_cmp++; if (a_if.shifted_out !== 8'h80 || a_if.shift_count !== 4'd0) begin n_bad++; $display("FAIL hold_after_done so=%h sc=%0d want 80 0", a_if.shifted_out, a_if.shift_count); end
  endtask

  task automatic test_leading_zeros();
    int lat;
    a_if.start = 1'b1; a_if.data_in = 16'h0013;
    @(posedge clk); #1;
    a_if.start = 1'b0; a_if.data_in = 16'hFFFF;
    wait_a(0, lat);
    lat = (lat == 0) ? 0 : lat + 1;
    n_cmp++; if (lat !== 13) begin n_bad++; $display("FAIL lz_latency got=%0d want=13", lat); end
    n_cmp++; if (a_if.shifted_out !== 8'h98 || a_if.shift_count !== 4'd11 || a_if.zero !== 1'b0) begin n_bad++; $display("FAIL lz_result so=%h sc=%0d z=%0b want 98 11 0", a_if.shifted_out, a_if.shift_count, a_if.zero); end
    @(posedge clk); #1;
  endtask

  task automatic test_zero();
    int lat;
    a_if.start = 1'b1; a_if.data_in = 16'h0000;
    wait_a(0, lat);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL zero_latency got=%0d want=1", lat); end
    n_cmp++; if (a_if.zero !== 1'b1 || a_if.shifted_out !== 8'h00 || a_if.shift_count !== 4'd0) begin n_bad++; $display("FAIL zero_result z=%0b so=%h sc=%0d want 1 00 0", a_if.zero, a_if.shifted_out, a_if.shift_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_max_ignore_start();
    int lat;
    a_if.start = 1'b1; a_if.data_in = 16'h0001;
    wait_a(5, lat);
    n_cmp++; if (lat !== 17) begin n_bad++; $display("FAIL max_latency got=%0d want=17", lat); end
    n_cmp++; if (a_if.shifted_out !== 8'h80 || a_if.shift_count !== 4'd15 || a_if.zero !== 1'b0) begin n_bad++; $display("FAIL max_result so=%h sc=%0d z=%0b want 80 15 0", a_if.shifted_out, a_if.shift_count, a_if.zero); end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (a_if.busy !== 1'b0) begin n_bad++; $display("FAIL ignored_start_busy got=%0b want=0", a_if.busy); end
  endtask

  task automatic test_reset_abort();
    int lat;
    int seen_done;
    a_if.start = 1'b1; a_if.data_in = 16'h0100;
    @(posedge clk); #1;
    a_if.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++; if (a_if.busy !== 1'b0 || a_if.done !== 1'b0) begin n_bad++; $display("FAIL abort_flags busy=%0b done=%0b want 0 0", a_if.busy, a_if.done); end
    n_cmp++; if (a_if.shifted_out !== 8'h00 || a_if.shift_count !== 4'd0 || a_if.zero !== 1'b0) begin n_bad++; $display("FAIL abort_outs so=%h sc=%0d z=%0b want 00 0 0", a_if.shifted_out, a_if.shift_count, a_if.zero); end
    seen_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (a_if.done) seen_done++;
    end
    n_cmp++; if (seen_done !== 0) begin n_bad++; $display("FAIL abort_no_done got=%0d pulses want=0", seen_done); end
    a_if.start = 1'b1; a_if.data_in = 16'h4000;
    wait_a(0, lat);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL post_abort_latency got=%0d want=3", lat); end
    n_cmp++; if (a_if.shifted_out !== 8'h80 || a_if.shift_count !== 4'd1) begin n_bad++; $display("FAIL post_abort_result so=%h sc=%0d want 80 1", a_if.shifted_out, a_if.shift_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat;
    b_if.start = 1'b1; b_if.data_in = 32'h00F0_0000;
    wait_b(lat);
    n_cmp++; if (lat !== 10) begin n_bad++; $display("FAIL b2b_first_latency got=%0d want=10", lat); end
    n_cmp++; if (b_if.shifted_out !== 4'hF || b_if.shift_count !== 5'd8) begin n_bad++; $display("FAIL b2b_first so=%h sc=%0d want f 8", b_if.shifted_out, b_if.shift_count); end
    b_if.start = 1'b1; b_if.data_in = 32'h0000_0001;
    @(posedge clk); #1;
    n_cmp++; if (b_if.busy !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_gap busy=%0b want=0", b_if.busy); end
    wait_b(lat);
    n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL b2b_second_latency got=%0d want=33", lat); end
    n_cmp++; if (b_if.shifted_out !== 4'h8 || b_if.shift_count !== 5'd31 || b_if.zero !== 1'b0) begin n_bad++; $display("FAIL b2b_second so=%h sc=%0d z=%0b want 8 31 0", b_if.shifted_out, b_if.shift_count, b_if.zero); end
  endtask

  initial begin
    test_reset();
    test_leading_zeros();
    test_zero();
    test_max_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
